// File: rtl/cdb_pkg.sv
// Shared constants and the CDB entry type for the common-data-bus arbiter.
package cdb_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(N_REQ);

  localparam int unsigned FU_INT  = 0;
  localparam int unsigned FU_MULT = 1;
  localparam int unsigned FU_DIV  = 2;
  localparam int unsigned FU_MEM  = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              branch;
    logic              branch_taken;
    logic              jalr;
  } cdb_entry_t;

endpackage

// File: rtl/rr_select.sv
// Combinational cyclic first-one finder: returns a one-hot grant for the first
// set mask bit at or after i_ptr, wrapping around.
module rr_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_idx;
  logic           w_found;

  // Rotate the mask so i_ptr lands at bit 0, find the lowest set bit, then
  // rotate the offset back into absolute index space.
  always_comb begin
    w_dbl   = {i_mask, i_mask} >> i_ptr;
    w_rot   = w_dbl[N-1:0];
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = PW'(k);
      end
    end
    w_idx = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
    o_grant = '0;
    if (w_found) o_grant[w_idx[PW-1:0]] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with branch/jalr priority override; the granted
// result is registered onto the CDB one cycle after its grant.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_branch,
  input  logic [N_REQ-1:0]        req_taken,
  input  logic [N_REQ-1:0]        req_jalr,
  output logic [N_REQ-1:0]        grant,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic                    cdb_branch,
  output logic                    cdb_branch_taken,
  output logic                    cdb_jalr
);

  logic [N_REQ-1:0] w_pmask;
  logic [N_REQ-1:0] w_pgrant;
  logic [N_REQ-1:0] w_agrant;
  logic [N_REQ-1:0] w_grant;
  logic [PTR_W-1:0] w_gidx;
  cdb_entry_t       w_entry [N_REQ];
  cdb_entry_t       w_sel;

  cdb_entry_t       r_cdb;
  logic [PTR_W-1:0] r_ptr;

  assign w_pmask = req & (req_branch | req_jalr);

  rr_select #(.N(N_REQ), .PW(PTR_W)) u_sel_prio (
    .i_mask  (w_pmask),
    .i_ptr   (r_ptr),
    .o_grant (w_pgrant)
  );

  rr_select #(.N(N_REQ), .PW(PTR_W)) u_sel_all (
    .i_mask  (req),
    .i_ptr   (r_ptr),
    .o_grant (w_agrant)
  );

  assign w_grant = (|w_pmask) ? w_pgrant : w_agrant;
  assign grant   = rst ? w_grant : '0;

  // jalr dominates branch; taken is only meaningful alongside branch.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_entry[i].valid        = req[i];
      w_entry[i].tag          = req_tag[i*TAG_W +: TAG_W];
      w_entry[i].data         = req_data[i*DATA_W +: DATA_W];
      w_entry[i].jalr         = req_jalr[i];
      w_entry[i].branch       = req_branch[i] & ~req_jalr[i];
      w_entry[i].branch_taken = req_taken[i] & req_branch[i];
    end
    w_gidx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_gidx = PTR_W'(i);
    end
    w_sel = w_entry[w_gidx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdb <= '0;
      r_ptr <= PTR_W'(FU_INT);
    end else if (|w_grant) begin
      r_cdb       <= w_sel;
      r_cdb.valid <= 1'b1;
      r_ptr       <= (w_gidx == PTR_W'(N_REQ-1)) ? '0 : w_gidx + PTR_W'(1);
    end else begin
      r_cdb.valid        <= 1'b0;
      r_cdb.branch       <= 1'b0;
      r_cdb.branch_taken <= 1'b0;
      r_cdb.jalr         <= 1'b0;
    end
  end

  assign cdb_valid        = r_cdb.valid;
  assign cdb_tag          = r_cdb.tag;
  assign cdb_data         = r_cdb.data;
  assign cdb_branch       = r_cdb.branch;
  assign cdb_branch_taken = r_cdb.branch_taken;
  assign cdb_jalr         = r_cdb.jalr;

endmodule
